// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared constants and encodings for the debug snapshot path
package debug_pkg;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_WAIT = 3'd4
    } state_e;

    // Where WAIT resumes once the current byte has left the UART
    typedef enum logic [1:0] {
        TAG_DATA = 2'd0,
        TAG_CSUM = 2'd1,
        TAG_FIN  = 2'd2
    } tag_e;

endpackage

// File: rtl/snap_shift_reg.sv
// rtl/snap_shift_reg.sv - wide shadow of the snapshot, drained one byte at a time from the low end
module snap_shift_reg #(
    parameter int unsigned DATA_BYTES = 168
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    shift,
    input  logic [8*DATA_BYTES-1:0] load_data,
    output logic [7:0]              byte_out
);

    logic [8*DATA_BYTES-1:0] shadow_q;
    logic [8*DATA_BYTES-1:0] shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = load_data;
        end else if (shift) begin
            shadow_d = shadow_q >> 8;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign byte_out = shadow_q[7:0];

endmodule

// File: rtl/snapshot_streamer.sv
// rtl/snapshot_streamer.sv - frames a shadowed debug snapshot as header, payload, XOR checksum for uart_tx
module snapshot_streamer
    import debug_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 168,
    parameter logic [7:0]  HEADER     = HEADER_DEFAULT
) (
    input  logic                    top_clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8*DATA_BYTES-1:0] snap_data,
    input  logic                    tx_done_tick,
    output logic                    tx_start,
    output logic [7:0]              tx_bus,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IW = $clog2(DATA_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES - 1);

    state_e          state_q, state_d;
    tag_e            tag_q, tag_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      chk_q, chk_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_bus_q, tx_bus_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load;
    logic            shift;
    logic [7:0]      shadow_byte;

    snap_shift_reg #(
        .DATA_BYTES(DATA_BYTES)
    ) u_shadow (
        .clk      (top_clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .load_data(snap_data),
        .byte_out (shadow_byte)
    );

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        tx_start_d = 1'b0;
        tx_bus_d   = tx_bus_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    chk_d   = 8'h00;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                tx_bus_d   = HEADER;
                tx_start_d = 1'b1;
                tag_d      = TAG_DATA;
                state_d    = ST_WAIT;
            end
            ST_DATA: begin
                tx_bus_d   = shadow_byte;
                chk_d      = chk_q ^ shadow_byte;
                shift      = 1'b1;
                idx_d      = idx_q + 1'b1;
                tx_start_d = 1'b1;
                // idx only counts up from zero, so equality marks the last payload byte
                tag_d      = (idx_q != LAST_IDX) ? TAG_DATA : TAG_CSUM;
                state_d    = ST_WAIT;
            end
            ST_CSUM: begin
                tx_bus_d   = chk_q;
                tx_start_d = 1'b1;
                tag_d      = TAG_FIN;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_tick) begin
                    case (tag_q)
                        TAG_DATA: state_d = ST_DATA;
                        TAG_CSUM: state_d = ST_CSUM;
                        default: begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge top_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tag_q      <= TAG_DATA;
            idx_q      <= '0;
            chk_q      <= 8'h00;
            tx_start_q <= 1'b0;
            tx_bus_q   <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            tx_start_q <= tx_start_d;
            tx_bus_q   <= tx_bus_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_bus   = tx_bus_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_snapshot_streamer.sv
// tb/tb_snapshot_streamer.sv - scoreboard bench for snapshot_streamer with a random-latency uart_tx model
module tb_snapshot_streamer;

    localparam int NB = 168;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_drv, start_poke, start;
    logic [8*NB-1:0] snap;
    logic            m_tick, spur_tick, spur_main, tick_big;
    logic            tx_start;
    logic [7:0]      tx_bus;
    logic            busy, done;

    logic            start1;
    logic [7:0]      snap1;
    logic            tick1;
    logic            tx_start1;
    logic [7:0]      tx_bus1;
    logic            busy1, done1;

    logic [7:0] sb[$];
    logic [7:0] sb1[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  done_cnt = 0, done1_cnt = 0, tx_cnt = 0;
    int  cnt = 0, cnt1 = 0;
    bit  poke_final = 0, poke_after_done = 0, spur_data_en = 0;
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

    assign start    = start_drv | start_poke;
    assign tick_big = m_tick | spur_tick | spur_main;

    snapshot_streamer #(.DATA_BYTES(NB)) dut (
        .top_clk     (clk),
        .rst         (rst),
        .start       (start),
        .snap_data   (snap),
        .tx_done_tick(tick_big),
        .tx_start    (tx_start),
        .tx_bus      (tx_bus),
        .busy        (busy),
        .done        (done)
    );

    snapshot_streamer #(.DATA_BYTES(1)) dut1 (
        .top_clk     (clk),
        .rst         (rst),
        .start       (start1),
        .snap_data   (snap1),
        .tx_done_tick(tick1),
        .tx_start    (tx_start1),
        .tx_bus      (tx_bus1),
        .busy        (busy1),
        .done        (done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input logic [8*NB-1:0] d);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        sb.push_back(8'hA5);
        for (int i = 0; i < NB; i++) begin
            b = d[8*i +: 8];
            sb.push_back(b);
            x ^= b;
        end
        sb.push_back(x);
    endfunction

    // Scoreboard consumer plus uart_tx model for both instances, evaluated once per falling edge
    initial begin
        start_poke = 1'b0;
        spur_tick  = 1'b0;
        m_tick     = 1'b0;
        tick1      = 1'b0;
        forever begin
            @(negedge clk);
            start_poke = 1'b0;
            spur_tick  = 1'b0;
            if (!rst) begin
                if (tx_start) begin
                    tx_cnt++;
                    if (sb.size() == 0) check_eq("extra_tx_start", 1, 0);
                    else check_eq("tx_byte", 32'(tx_bus), 32'(sb.pop_front()));
                    cnt = int'($urandom_range(1, 20));
                end
                if (done) begin
                    done_cnt++;
                    check_eq("busy_low_at_done", 32'(busy), 0);
                    check_eq("busy_high_before_done", 32'(busy_prev), 1);
                    if (poke_after_done) begin
                        poke_after_done = 0;
                        start_poke = 1'b1;
                        push_frame(snap);
                    end
                end
                if (m_tick) begin
                    m_tick = 1'b0;
                    spur_tick = spur_data_en;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        m_tick = 1'b1;
                        if (poke_final && sb.size() == 0) begin
                            poke_final = 0;
                            start_poke = 1'b1;
                        end
                    end
                end
                if (tx_start1) begin
                    if (sb1.size() == 0) check_eq("extra_tx_start1", 1, 0);
                    else check_eq("tx1_byte", 32'(tx_bus1), 32'(sb1.pop_front()));
                    cnt1 = int'($urandom_range(1, 20));
                end
                if (done1) done1_cnt++;
                tick1 = 1'b0;
                if (cnt1 > 0) begin
                    cnt1--;
                    if (cnt1 == 0) tick1 = 1'b1;
                end
            end else begin
                cnt    = 0;
                cnt1   = 0;
                m_tick = 1'b0;
                tick1  = 1'b0;
            end
            busy_prev = busy;
        end
    end

    task automatic start_frame();
        push_frame(snap);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        check_eq("busy_after_start", 32'(busy), 1);
        check_eq("no_tx_start_in_hdr", 32'(tx_start), 0);
    endtask

    task automatic wait_frame(input int d0);
        int c = 0;
        while (done_cnt == d0 && c < 8000) begin
            @(negedge clk);
            c++;
        end
        check_eq("frame_done_in_time", 32'(done_cnt != d0), 1);
        repeat (3) @(negedge clk);
        check_eq("done_once", 32'(done_cnt), 32'(d0 + 1));
        check_eq("sb_drained", 32'(sb.size()), 0);
        check_eq("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int d0;
        int t0;
        int c;
        int lat;
        rst       = 1'b1;
        start_drv = 1'b0;
        spur_main = 1'b0;
        start1    = 1'b0;
        snap      = '0;
        snap1     = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_start", 32'(tx_start), 0);
        check_eq("rst_tx_bus", 32'(tx_bus), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_tx_start1", 32'(tx_start1), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: incrementing bytes
        for (int i = 0; i < NB; i++) snap[8*i +: 8] = 8'(i);
        d0 = done_cnt;
        start_frame();
        @(negedge clk);
        check_eq("hdr_latency", 32'(tx_start), 1);
        wait_frame(d0);

        // 2: all-ones image, bus disturbed right after capture
        snap = '1;
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < NB; i++) snap[8*i +: 8] = 8'($urandom);
        wait_frame(d0);

        // 3: start during HDR, WAIT and the final tick are ignored; start in the done cycle is taken
        for (int i = 0; i < NB; i++) snap[8*i +: 8] = 8'($urandom);
        d0 = done_cnt;
        push_frame(snap);
        start_drv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start_drv = 1'b0;
        repeat (5) @(negedge clk);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        poke_final = 1;
        poke_after_done = 1;
        c = 0;
        while (done_cnt < d0 + 2 && c < 16000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check_eq("two_frames_done", 32'(done_cnt), 32'(d0 + 2));
        check_eq("sb_drained_t3", 32'(sb.size()), 0);
        poke_final = 0;
        poke_after_done = 0;

        // 4: reset mid-frame
        for (int i = 0; i < NB; i++) snap[8*i +: 8] = 8'($urandom);
        t0 = tx_cnt;
        start_frame();
        c = 0;
        while (tx_cnt < t0 + 51 && c < 8000) begin
            @(negedge clk);
            c++;
        end
        check_eq("reached_byte_50", 32'(tx_cnt >= t0 + 51), 1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_tx_start", 32'(tx_start), 0);
        check_eq("rst_mid_busy", 32'(busy), 0);
        check_eq("rst_mid_tx_bus", 32'(tx_bus), 0);
        sb.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check_eq("no_done_after_rst", 32'(done_cnt), 32'(d0));
        for (int i = 0; i < NB; i++) snap[8*i +: 8] = 8'($urandom);
        start_frame();
        wait_frame(d0);

        // 5: spurious ticks in IDLE, HDR and DATA cycles
        t0 = tx_cnt;
        spur_main = 1'b1;
        @(negedge clk);
        spur_main = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("idle_tick_busy", 32'(busy), 0);
        check_eq("idle_tick_no_tx", 32'(tx_cnt), 32'(t0));
        for (int i = 0; i < NB; i++) snap[8*i +: 8] = 8'($urandom);
        d0 = done_cnt;
        spur_data_en = 1;
        push_frame(snap);
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        spur_main = 1'b1;
        @(negedge clk);
        spur_main = 1'b0;
        wait_frame(d0);
        spur_data_en = 0;

        // 6: single-byte payload
        snap1 = 8'h3C;
        sb1.push_back(8'hA5);
        sb1.push_back(8'h3C);
        sb1.push_back(8'h3C);
        d0 = done1_cnt;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 1;
        while (!tx_start1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("db1_latency", 32'(lat), 2);
        c = 0;
        while (done1_cnt == d0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check_eq("db1_done_once", 32'(done1_cnt), 32'(d0 + 1));
        check_eq("db1_sb_drained", 32'(sb1.size()), 0);
        check_eq("db1_busy_idle", 32'(busy1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
